alu_seq_ctrl: RTL and testbench



---
 rtl/alu_seq_pkg.sv | 27 ++
 rtl/alu_seq_mscan.sv | 37 +++
 rtl/alu_seq_ctrl.sv | 128 ++++++++++++
 tb/tb_alu_seq_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared types and default width for the ALU operation sequencer
package alu_seq_pkg;

    localparam int ALU_SEQ_WIDTH = 8;

    typedef enum logic [1:0] {
        OP_PASS = 2'd0,
        OP_SUB  = 2'd1,
        OP_MUL  = 2'd2,
        OP_FLAG = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        SRCA_REG  = 2'b00,
        SRCA_NEG  = 2'b01,
        SRCA_FL   = 2'b10,
        SRCA_ZERO = 2'b11
    } srca_sel_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_MUL_LOOP,
        ST_DONE
    } state_e;

endpackage

// File: rtl/alu_seq_mscan.sv
// rtl/alu_seq_mscan.sv - multiplier register with per-iteration bit select
// Ports: clk, rst_n (async active-low); load_i/mult_i capture the multiplier;
//        iter_i selects the bit presented on bit_o; rest_zero_o (only with
//        ALU_SEQ_EARLY_EXIT_EN) flags that all bits above iter_i are zero.
module alu_seq_mscan #(
    parameter int WIDTH = 8,
    parameter int IW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [WIDTH-1:0] mult_i,
    input  logic [IW-1:0]    iter_i,
`ifdef ALU_SEQ_EARLY_EXIT_EN
    output logic             rest_zero_o,
`endif
    output logic             bit_o
);

    logic [WIDTH-1:0] mreg_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mreg_q <= '0;
        end else if (load_i) begin
            mreg_q <= mult_i;
        end
    end

    assign bit_o = mreg_q[iter_i];

`ifdef ALU_SEQ_EARLY_EXIT_EN
    // Drop bits [iter_i:0]; whatever is left are the multiplier bits still to scan.
    assign rest_zero_o = (((mreg_q >> iter_i) >> 1) == '0);
`endif

endmodule

// File: rtl/alu_seq_ctrl.sv
// rtl/alu_seq_ctrl.sv - multi-cycle PASS/SUB/FLAG/MUL sequencer driving ALU source-A and accumulator strobes
// Ports: clk, rst_n (async active-low); start/op/mult_in request (accepted when ready);
//        ready, busy, done status; sel_srca, acc_clr, acc_we, shamt datapath controls.
// Build option: ALU_SEQ_EARLY_EXIT_EN ends MUL once no multiplier bits remain.
module alu_seq_ctrl
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = ALU_SEQ_WIDTH,
    parameter int IW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] mult_in,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [1:0]       sel_srca,
    output logic             acc_clr,
    output logic             acc_we,
    output logic [IW-1:0]    shamt
);

    state_e      state_q, state_d;
    op_e         op_q, op_d;
    logic [IW-1:0] iter_q, iter_d;
    srca_sel_e   srca;
    logic        load;
    logic        mbit;
    logic        mul_last;

`ifdef ALU_SEQ_EARLY_EXIT_EN
    logic rest_zero;
`endif

    alu_seq_mscan #(
        .WIDTH (WIDTH),
        .IW    (IW)
    ) u_mscan (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_i      (load),
        .mult_i      (mult_in),
        .iter_i      (iter_q),
`ifdef ALU_SEQ_EARLY_EXIT_EN
        .rest_zero_o (rest_zero),
`endif
        .bit_o       (mbit)
    );

`ifdef ALU_SEQ_EARLY_EXIT_EN
    assign mul_last = (iter_q == IW'(WIDTH - 1)) || rest_zero;
`else
    assign mul_last = (iter_q == IW'(WIDTH - 1));
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            op_q    <= OP_PASS;
            iter_q  <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            iter_q  <= iter_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        iter_d  = iter_q;
        load    = 1'b0;
        ready   = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        acc_clr = 1'b0;
        acc_we  = 1'b0;
        shamt   = '0;
        srca    = SRCA_ZERO;

        unique case (state_q)
            ST_IDLE: begin
                ready = 1'b1;
                if (start) begin
                    // Clear lands in the accept cycle so the first EXEC/loop write sees acc=0.
                    acc_clr = 1'b1;
                    load    = 1'b1;
                    iter_d  = '0;
                    op_d    = op_e'(op);
                    state_d = (op_e'(op) == OP_MUL) ? ST_MUL_LOOP : ST_EXEC;
                end
            end
            ST_EXEC: begin
                busy   = 1'b1;
                acc_we = 1'b1;
                unique case (op_q)
                    OP_PASS: srca = SRCA_REG;
                    OP_SUB:  srca = SRCA_NEG;
                    OP_FLAG: srca = SRCA_FL;
                    default: srca = SRCA_ZERO;
                endcase
                state_d = ST_DONE;
            end
            ST_MUL_LOOP: begin
                busy   = 1'b1;
                acc_we = 1'b1;
                shamt  = iter_q;
                // A zero multiplier bit still writes, adding zero, so the cycle count is fixed.
                srca   = mbit ? SRCA_REG : SRCA_ZERO;
                if (mul_last) begin
                    state_d = ST_DONE;
                end else begin
                    iter_d = iter_q + 1'b1;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign sel_srca = srca;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb/tb_alu_seq_ctrl.sv - scoreboard bench for alu_seq_ctrl
module tb_alu_seq_ctrl;

    localparam int WIDTH = 8;
    localparam logic [15:0] A_OP = 16'h0013;

    typedef struct packed {
        logic       ready;
        logic       busy;
        logic       done;
        logic [1:0] sel;
        logic       clr;
        logic       we;
        logic [2:0] sh;
    } outs_t;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] mult_in;
    logic             ready, busy, done, acc_clr, acc_we;
    logic [1:0]       sel_srca;
    logic [2:0]       shamt;

    outs_t       obs;
    outs_t       exp_q[$];
    logic [15:0] res_q[$];
    logic [15:0] acc;
    int          n_cmp = 0;
    int          n_fail = 0;

    alu_seq_ctrl #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op       (op),
        .mult_in  (mult_in),
        .ready    (ready),
        .busy     (busy),
        .done     (done),
        .sel_srca (sel_srca),
        .acc_clr  (acc_clr),
        .acc_we   (acc_we),
        .shamt    (shamt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign obs = '{ready, busy, done, sel_srca, acc_clr, acc_we, shamt};

    // Accumulator datapath: A operand 0x13, negated A, flag constant 1, zero.
    always @(posedge clk) begin
        logic [15:0] src;
        case (sel_srca)
            2'b00:   src = A_OP;
            2'b01:   src = -A_OP;
            2'b10:   src = 16'h0001;
            default: src = 16'h0000;
        endcase
        if (acc_clr)     acc <= 16'h0000;
        else if (acc_we) acc <= acc + (src << shamt);
    end

    function automatic outs_t mk(input logic r, b, d, input logic [1:0] s,
                                 input logic c, w, input logic [2:0] sh);
        mk = '{r, b, d, s, c, w, sh};
    endfunction

    // Drive one request from just after a posedge and check every cycle until idle again.
    task automatic test_op(input string name, input logic [1:0] o, input logic [7:0] m,
                           input int poke_k);
        int          nloop;
        int          k;
        outs_t       e;
        logic [15:0] res;
        logic [15:0] r;
        exp_q.push_back(mk(1, 0, 0, 2'b11, 1, 0, 0));
        case (o)
            2'd0: begin exp_q.push_back(mk(0, 1, 0, 2'b00, 0, 1, 0)); res = A_OP; end
            2'd1: begin exp_q.push_back(mk(0, 1, 0, 2'b01, 0, 1, 0)); res = 16'hFFED; end
            2'd3: begin exp_q.push_back(mk(0, 1, 0, 2'b10, 0, 1, 0)); res = 16'h0001; end
            default: begin
                nloop = WIDTH;
`ifdef ALU_SEQ_EARLY_EXIT_EN
                nloop = 1;
                for (int i = 1; i < WIDTH; i++) if (m[i]) nloop = i + 1;
`endif
                for (int i = 0; i < nloop; i++)
                    exp_q.push_back(mk(0, 1, 0, m[i] ? 2'b00 : 2'b11, 0, 1, 3'(i)));
                res = A_OP * {8'h00, m};
            end
        endcase
        exp_q.push_back(mk(0, 0, 1, 2'b11, 0, 0, 0));
        exp_q.push_back(mk(1, 0, 0, 2'b11, 0, 0, 0));
        res_q.push_back(res);

        start = 1'b1; op = o; mult_in = m;
        k = 0;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            e = exp_q.pop_front();
            n_cmp++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL %s cycle %0d: outputs got %b want %b", name, k, obs, e);
            end
            if (e.done) begin
                r = res_q.pop_front();
                n_cmp++;
                if (acc !== r) begin
                    n_fail++;
                    $display("FAIL %s acc: got %h want %h", name, acc, r);
                end
            end
            @(posedge clk); #1;
            if (k == 0) begin start = 1'b0; mult_in = 8'hFF; end
            if (poke_k > 0 && k == poke_k - 1) begin start = 1'b1; op = 2'd1; end
            if (poke_k > 0 && k == poke_k) start = 1'b0;
            k++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1; start = 1'b0; op = 2'd0; mult_in = '0;
        #12 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (obs !== mk(1, 0, 0, 2'b11, 0, 0, 0)) begin
            n_fail++;
            $display("FAIL reset_async: got %b want %b", obs, mk(1, 0, 0, 2'b11, 0, 0, 0));
        end
        @(posedge clk); #1 rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++;
            if (obs !== mk(1, 0, 0, 2'b11, 0, 0, 0)) begin
                n_fail++;
                $display("FAIL reset_idle cycle %0d: got %b want %b", i, obs,
                         mk(1, 0, 0, 2'b11, 0, 0, 0));
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_single_ops();
        test_op("pass", 2'd0, 8'h00, 0);
        test_op("sub",  2'd1, 8'h00, 0);
        test_op("flag", 2'd3, 8'h00, 0);
    endtask

    task automatic test_mul();
        test_op("mul_a5", 2'd2, 8'hA5, 0);
    endtask

    task automatic test_ignore_busy();
        test_op("mul_ignore", 2'd2, 8'hA5, 4);
    endtask

    task automatic test_early_exit();
        test_op("ee_mul3", 2'd2, 8'h03, 0);
        test_op("ee_mul0", 2'd2, 8'h00, 0);
    endtask

    task automatic test_reset_mid();
        start = 1'b1; op = 2'd2; mult_in = 8'hA5;
        @(posedge clk); #1 start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_cmp++;
            if (done !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_mid loop %0d done: got %b want 0", i, done);
            end
            @(posedge clk);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (obs !== mk(1, 0, 0, 2'b11, 0, 0, 0)) begin
            n_fail++;
            $display("FAIL reset_mid abort: got %b want %b", obs, mk(1, 0, 0, 2'b11, 0, 0, 0));
        end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid held done: got %b want 0", done);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        test_op("mul_after_reset", 2'd2, 8'hA5, 0);
    endtask

    task automatic test_back_to_back();
        int    k;
        outs_t e;
        logic [15:0] r;
        exp_q.push_back(mk(1, 0, 0, 2'b11, 1, 0, 0));
        exp_q.push_back(mk(0, 1, 0, 2'b00, 0, 1, 0));
        exp_q.push_back(mk(0, 0, 1, 2'b11, 0, 0, 0));
        exp_q.push_back(mk(1, 0, 0, 2'b11, 1, 0, 0));
        exp_q.push_back(mk(0, 1, 0, 2'b01, 0, 1, 0));
        exp_q.push_back(mk(0, 0, 1, 2'b11, 0, 0, 0));
        exp_q.push_back(mk(1, 0, 0, 2'b11, 0, 0, 0));
        res_q.push_back(A_OP);
        res_q.push_back(16'hFFED);
        start = 1'b1; op = 2'd0;
        k = 0;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            e = exp_q.pop_front();
            n_cmp++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL b2b cycle %0d: outputs got %b want %b", k, obs, e);
            end
            if (e.done) begin
                r = res_q.pop_front();
                n_cmp++;
                if (acc !== r) begin
                    n_fail++;
                    $display("FAIL b2b acc: got %h want %h", acc, r);
                end
            end
            @(posedge clk); #1;
            if (k == 0) op = 2'd1;
            if (k == 3) start = 1'b0;
            k++;
        end
    endtask

    initial begin
        test_reset();
        test_single_ops();
        test_mul();
        test_ignore_busy();
        test_early_exit();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
